// File: rtl/frame_fetch_pkg.sv
// Shared constants and state encoding for the frame buffer streaming reader.
package frame_fetch_pkg;

    localparam int unsigned PIX_W     = 24;
    localparam int unsigned FB_ADDR_W = 17;
    localparam int unsigned FB_H      = 320;
    localparam int unsigned FB_V      = 240;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StDrain = 2'd2
    } fetch_state_e;

endpackage : frame_fetch_pkg

// File: rtl/fetch_skid_fifo.sv
// Small synchronous FIFO parking returned pixels; head is readable with zero latency.
module fetch_skid_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 25
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [Width-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           head_o,
    output logic                       empty_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    // Accept a push when there is room, or when a pop frees a slot in the same cycle.
    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && ((count_q != CntW'(Depth)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only observed through a valid head.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Head reads as zero when empty so the pixel output is quiet after reset.
    always_comb begin
        empty_o = (count_q == '0);
        head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
        count_o = count_q;
    end

endmodule : fetch_skid_fifo

// File: rtl/frame_fetch.sv
// Raster-order frame buffer reader with line/pixel replication into the pixel FIFO.
module frame_fetch
    import frame_fetch_pkg::*;
#(
    parameter int unsigned H_SRC      = FB_H,
    parameter int unsigned V_SRC      = FB_V,
    parameter int unsigned ADDR_W     = FB_ADDR_W,
    parameter int unsigned DATA_W     = PIX_W,
    parameter int unsigned SCALE      = 2,
    parameter int unsigned READ_LAT   = 1,
    parameter int unsigned SKID_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              fifo_full,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_din,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned CntW = $clog2(SKID_DEPTH + 1);
    localparam int unsigned RepW = 3;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] col_q, col_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic [RepW-1:0]   rep_q, rep_d;
    logic [RepW-1:0]   wcnt_q, wcnt_d;
    logic [READ_LAT-1:0] vld_pipe_q, vld_pipe_d;
    logic [READ_LAT-1:0] last_pipe_q, last_pipe_d;

    logic              issue_last;
    logic [CntW-1:0]   inflight;
    logic [CntW:0]     occupancy;
    logic [CntW-1:0]   skid_count;
    logic              skid_empty;
    logic              skid_pop;
    logic [DATA_W:0]   skid_head;

    // Last read of the frame: final pixel of the final replica of the final line.
    always_comb begin
        issue_last = rd_en
                     && (col_q == ADDR_W'(H_SRC - 1))
                     && (rep_q == RepW'(SCALE - 1))
                     && (row_q == ADDR_W'(V_SRC - 1));
    end

    // Credit: reads in flight plus parked entries never exceed the skid depth.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(READ_LAT); i++) begin
            inflight = inflight + CntW'(vld_pipe_q[i]);
        end
        occupancy = {1'b0, skid_count} + {1'b0, inflight};
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; DRAIN leaves on the pop of the tagged entry, which is the frame_done cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (en) state_d = StIssue;
            StIssue: if (issue_last) state_d = StDrain;
            StDrain: if (frame_done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: read issue and status.
    always_comb begin
        busy    = (state_q != StIdle);
        rd_en   = (state_q == StIssue) && (occupancy < (CntW + 1)'(SKID_DEPTH));
        rd_addr = (state_q == StIssue) ? (line_base_q + col_q) : '0;
    end

    // Raster walk with line replication; counters restart at every frame start.
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        rep_d       = rep_q;
        line_base_d = line_base_q;
        if (state_q == StIdle && en) begin
            col_d       = '0;
            row_d       = '0;
            rep_d       = '0;
            line_base_d = '0;
        end else if (rd_en) begin
            if (col_q == ADDR_W'(H_SRC - 1)) begin
                col_d = '0;
                if (rep_q == RepW'(SCALE - 1)) begin
                    rep_d       = '0;
                    row_d       = row_q + 1'b1;
                    line_base_d = line_base_q + ADDR_W'(H_SRC);
                end else begin
                    rep_d = rep_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Read-latency tracker: a valid/last bit per outstanding read.
    always_comb begin
        vld_pipe_d     = vld_pipe_q;
        last_pipe_d    = last_pipe_q;
        vld_pipe_d[0]  = rd_en;
        last_pipe_d[0] = issue_last;
        for (int i = 1; i < int'(READ_LAT); i++) begin
            vld_pipe_d[i]  = vld_pipe_q[i-1];
            last_pipe_d[i] = last_pipe_q[i-1];
        end
    end

    // Pixel replication: each skid entry is written SCALE times, popped on the last write.
    always_comb begin
        fifo_wr_en = ~skid_empty & ~fifo_full;
        fifo_din   = skid_head[DATA_W-1:0];
        skid_pop   = fifo_wr_en && (wcnt_q == RepW'(SCALE - 1));
        frame_done = skid_pop && skid_head[DATA_W];
        wcnt_d     = wcnt_q;
        if (fifo_wr_en) begin
            wcnt_d = skid_pop ? '0 : wcnt_q + 1'b1;
        end
    end

    // Datapath registers; reset flushes in-flight reads so stale returns are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            rep_q       <= '0;
            line_base_q <= '0;
            wcnt_q      <= '0;
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            rep_q       <= rep_d;
            line_base_q <= line_base_d;
            wcnt_q      <= wcnt_d;
            vld_pipe_q  <= vld_pipe_d;
            last_pipe_q <= last_pipe_d;
        end
    end

    fetch_skid_fifo #(
        .Depth (SKID_DEPTH),
        .Width (DATA_W + 1)
    ) u_skid (
        .clk_i       (clk),
        .rst_i       (rst),
        .push_i      (vld_pipe_q[READ_LAT-1]),
        .push_data_i ({last_pipe_q[READ_LAT-1], rd_data}),
        .pop_i       (skid_pop),
        .head_o      (skid_head),
        .empty_o     (skid_empty),
        .count_o     (skid_count)
    );

endmodule : frame_fetch

// File: tb/tb_frame_fetch.sv
// Scoreboard bench for frame_fetch on a 4x2 source with 2x replication.
module tb_frame_fetch;

    localparam int unsigned H  = 4;
    localparam int unsigned V  = 2;
    localparam int unsigned S  = 2;
    localparam int unsigned AW = 17;
    localparam int unsigned DW = 24;
    localparam int unsigned WR_PER_FRAME = H * V * S * S;
    localparam int unsigned RD_PER_FRAME = H * V * S;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, en, fifo_full;
    logic [AW-1:0] rd_addr;
    logic          rd_en;
    logic [DW-1:0] rd_data = '0;
    logic          fifo_wr_en;
    logic [DW-1:0] fifo_din;
    logic          busy, frame_done;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   reads = 0, writes = 0, done_cnt = 0, frame_writes = 0;
    int   done_cyc = 0, first_rd_cyc = 0, first_wr_cyc = 0;
    bit   first_rd_pending = 0, first_wr_pending = 0;
    int   max_addr = 0, max_skid = 0;
    bit   rand_full = 0;

    frame_fetch #(
        .H_SRC      (H),
        .V_SRC      (V),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .SCALE      (S),
        .READ_LAT   (1),
        .SKID_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .rd_addr    (rd_addr),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Frame buffer model: pixel value equals its address; junk when no read was issued.
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rd_data <= rd_en ? DW'(rd_addr) : 24'hBADBAD;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame();
        exp_t e;
        for (int r = 0; r < int'(V); r++)
            for (int rp = 0; rp < int'(S); rp++)
                for (int c = 0; c < int'(H); c++)
                    for (int p = 0; p < int'(S); p++) begin
                        e.data = DW'(r * H + c);
                        e.last = (r == V - 1) && (rp == S - 1) && (c == H - 1) && (p == S - 1);
                        sb.push_back(e);
                    end
    endtask

    task automatic start_frame();
        push_frame();
        first_rd_pending = 1;
        first_wr_pending = 1;
        en = 1;
        tick();
        en = 0;
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check(tag, done_cnt, target);
    endtask

    // Monitor and scoreboard, sampled on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (int'(dut.skid_count) > max_skid) max_skid = int'(dut.skid_count);
            if (rd_en) begin
                reads++;
                if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
                if (first_rd_pending) begin
                    first_rd_cyc = cyc;
                    first_rd_pending = 0;
                end
            end
            if (fifo_wr_en) begin
                writes++;
                frame_writes++;
                if (first_wr_pending) begin
                    first_wr_cyc = cyc;
                    first_wr_pending = 0;
                end
                if (sb.size() == 0) begin
                    check("sb_extra_write", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("pixel", fifo_din, e.data);
                    check("done_tag", frame_done, e.last);
                end
            end else if (frame_done) begin
                check("done_without_write", frame_done, 0);
            end
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
                frame_writes = 0;
            end
        end
    end

    // Pseudo-random backpressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_full) fifo_full = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int rd0, wr0, d0;
        bit hit;
        void'($urandom(32'd1234));
        rst = 1; en = 0; fifo_full = 0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_wr_en", fifo_wr_en, 0);
        check("rst_din", fifo_din, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        rst = 0;
        tick();

        // Unstalled frame.
        rd0 = reads; wr0 = writes;
        start_frame();
        wait_done(done_cnt + 1, 300, "t1_done");
        check("t1_writes", writes - wr0, WR_PER_FRAME);
        check("t1_reads", reads - rd0, RD_PER_FRAME);
        check("t1_first_wr_lat", first_wr_cyc - first_rd_cyc, 2);
        @(negedge clk);
        check("t1_busy_after", busy, 0);
        tick();

        // Full held for 20 cycles: credit caps reads at 4, no writes.
        rd0 = reads; wr0 = writes;
        fifo_full = 1;
        start_frame();
        repeat (20) tick();
        check("t2_reads_stalled", reads - rd0, 4);
        check("t2_writes_stalled", writes - wr0, 0);
        fifo_full = 0;
        wait_done(done_cnt + 1, 300, "t2_done");
        check("t2_writes", writes - wr0, WR_PER_FRAME);
        tick();

        // Random backpressure.
        wr0 = writes;
        rand_full = 1;
        start_frame();
        wait_done(done_cnt + 1, 600, "t3_done");
        rand_full = 0;
        fifo_full = 0;
        check("t3_writes", writes - wr0, WR_PER_FRAME);
        tick();

        // Reset at write #10, then restart from address 0.
        d0 = done_cnt;
        start_frame();
        hit = 0;
        fork
            begin
                wait (frame_writes >= 10);
                hit = 1;
            end
            repeat (200) @(posedge clk);
        join_any
        disable fork;
        check("t4_reached_w10", frame_writes, 10);
        rst = 1;
        sb.delete();
        @(negedge clk);
        check("t4_rd_en", rd_en, 0);
        check("t4_rd_addr", rd_addr, 0);
        check("t4_wr_en", fifo_wr_en, 0);
        check("t4_din", fifo_din, 0);
        check("t4_busy", busy, 0);
        check("t4_skid_empty", dut.skid_count, 0);
        check("t4_no_done", done_cnt, d0);
        rst = 0;
        frame_writes = 0;
        tick();
        wr0 = writes;
        start_frame();
        wait_done(done_cnt + 1, 300, "t4_done");
        check("t4_writes", writes - wr0, WR_PER_FRAME);

        // en held: back-to-back frames, then drop en mid-frame.
        tick();
        push_frame();
        push_frame();
        en = 1;
        wait_done(done_cnt + 1, 300, "t5_done_a");
        first_rd_pending = 1;
        repeat (5) tick();
        en = 0;
        check("t5_gap", first_rd_cyc - done_cyc, 2);
        wait_done(done_cnt + 1, 300, "t5_done_b");
        rd0 = reads;
        repeat (10) tick();
        check("t5_idle_busy", busy, 0);
        check("t5_idle_reads", reads - rd0, 0);

        check("sb_empty", sb.size(), 0);
        check("skid_max_le4", (max_skid <= 4), 1);
        check("max_addr", max_addr, H * V - 1);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_frame_fetch
